// File: rtl/full_stage_in_ctrl_if.sv
// Stream-in / memory-write / bank-handoff bundle for full_stage_in_ctrl.
// slave = the controller, master = the environment driving it.
interface full_stage_in_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_vld;
  logic                  in_fst;
  logic                  in_rdy;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [ADDR_WIDTH-1:0] mem_wr_address;
  logic                  mem_wr_vld;
  logic                  frame_done;
  logic                  rd_vld;
  logic                  rd_bank;
  logic                  rd_release;
  logic                  err_restart;
  logic [7:0]            drop_count;

  modport slave (
    input  in_data, in_vld, in_fst, rd_release,
    output in_rdy, mem_wr_data, mem_wr_address, mem_wr_vld, frame_done,
           rd_vld, rd_bank, err_restart, drop_count
  );

  modport master (
    output in_data, in_vld, in_fst, rd_release,
    input  in_rdy, mem_wr_data, mem_wr_address, mem_wr_vld, frame_done,
           rd_vld, rd_bank, err_restart, drop_count
  );
endinterface

// File: rtl/full_stage_in_ctrl.sv
// Receive side of a stage stream: frames words on fst, writes them into a
// ping-pong input memory and hands completed banks to the stage core.
module full_stage_in_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int FRAME_LEN  = 48   // 1 .. 2**(ADDR_WIDTH-1)
) (
  input  logic                 clk,
  input  logic                 reset,   // async, active low
  full_stage_in_ctrl_if.slave  bus
);
  localparam int IW = ADDR_WIDTH - 1;
  localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic                  wr_bank;
  logic                  rd_bank_q;
  logic [1:0]            full_cnt;
  logic [7:0]            drop_q;
  logic                  rdy_q;
  logic                  rd_vld_q;
  logic                  wr_vld_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  done_q;
  logic                  err_q;

  logic                  accept;
  logic                  wr_en;
  logic [IW-1:0]         wr_idx;
  logic                  restart;
  logic                  drop;
  logic                  complete;
  logic                  release_ok;
  logic [1:0]            full_nxt;

  // rdy is a flop so upstream never sees a path from vld/fst back to rdy
  assign accept = bus.in_vld & rdy_q;

  // Decode what the accepted word does this cycle
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    restart = 1'b0;
    drop    = 1'b0;
    if (accept) begin
      if (state == IDLE) begin
        if (bus.in_fst) begin
          wr_en  = 1'b1;
          wr_idx = '0;
        end else begin
          drop = 1'b1;
        end
      end else begin
        wr_en = 1'b1;
        if (bus.in_fst) begin
          // fst mid-frame: restart the frame in the same bank
          wr_idx  = '0;
          restart = 1'b1;
        end
      end
    end
    complete   = wr_en && (wr_idx == LAST);
    release_ok = bus.rd_release && (full_cnt != 2'd0);
    full_nxt   = full_cnt + {1'b0, complete} - {1'b0, release_ok};
  end

  // Frame FSM, bank bookkeeping and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      wr_bank   <= 1'b0;
      rd_bank_q <= 1'b0;
      full_cnt  <= 2'd0;
      drop_q    <= 8'd0;
      rdy_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (complete) begin
        state <= IDLE;
        idx   <= '0;
      end else if (wr_en) begin
        state <= FILL;
        idx   <= wr_idx + 1'b1;
      end
      wr_bank   <= wr_bank ^ complete;
      rd_bank_q <= rd_bank_q ^ release_ok;
      full_cnt  <= full_nxt;
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      rdy_q     <= (full_nxt != 2'd2);
      rd_vld_q  <= (full_cnt != 2'd0);
      wr_vld_q  <= wr_en;
      if (wr_en) begin
        wr_data_q <= bus.in_data;
        wr_addr_q <= {wr_bank, wr_idx};
      end
      done_q <= complete;
      err_q  <= restart;
    end
  end

  assign bus.in_rdy         = rdy_q;
  assign bus.mem_wr_vld     = wr_vld_q;
  assign bus.mem_wr_data    = wr_data_q;
  assign bus.mem_wr_address = wr_addr_q;
  assign bus.frame_done     = done_q;
  assign bus.rd_vld         = rd_vld_q;
  assign bus.rd_bank        = rd_bank_q;
  assign bus.err_restart    = err_q;
  assign bus.drop_count     = drop_q;
endmodule

// File: tb/tb_full_stage_in_ctrl.sv
// Bench for full_stage_in_ctrl with FRAME_LEN=4: directed scenarios plus a
// randomized run against a frame-position reference model.
module tb_full_stage_in_ctrl;
  localparam int DW = 32;
  localparam int AW = 7;
  localparam int FL = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  full_stage_in_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  full_stage_in_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: pos = -1 while hunting for fst, else next word slot
  int          m_pos, m_full, m_wbank, m_rbank, m_drop;
  logic        e_wr_vld, e_done, e_err, e_rdvld, e_rdy;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  task automatic model_reset();
    m_pos = -1; m_full = 0; m_wbank = 0; m_rbank = 0; m_drop = 0;
    e_wr_vld = 0; e_done = 0; e_err = 0; e_rdvld = 0; e_rdy = 0;
    e_addr = '0; e_data = '0;
  endtask

  task automatic model_step(input logic vld, input logic fst,
                            input logic [DW-1:0] d, input logic rel);
    int  slot;
    bit  store, comp, relok;
    store = 0; comp = 0; slot = 0;
    e_err = 0;
    if (vld && e_rdy) begin
      if (fst) begin
        e_err = (m_pos > 0);
        slot  = 0; store = 1;
      end else if (m_pos < 0) begin
        if (m_drop < 255) m_drop++;
      end else begin
        slot = m_pos; store = 1;
      end
    end
    e_wr_vld = store;
    if (store) begin
      e_addr = AW'(m_wbank * 64 + slot);
      e_data = d;
      if (slot == FL - 1) begin
        comp = 1; m_pos = -1; m_wbank = 1 - m_wbank;
      end else begin
        m_pos = slot + 1;
      end
    end
    e_done  = comp;
    e_rdvld = (m_full != 0);
    relok   = rel && (m_full != 0);
    m_full  = m_full + int'(comp) - int'(relok);
    if (relok) m_rbank = 1 - m_rbank;
    e_rdy   = (m_full != 2);
  endtask

  // one clock: drive inputs, advance model, sample 1ns after the edge
  task automatic cyc(input logic vld, input logic fst,
                     input logic [DW-1:0] d, input logic rel);
    bus.in_vld = vld; bus.in_fst = fst; bus.in_data = d; bus.rd_release = rel;
    model_step(vld, fst, d, rel);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    bus.in_vld = 0; bus.in_fst = 0; bus.in_data = '0; bus.rd_release = 0;
    reset = 0; model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1;
    cyc(0, 0, '0, 0);
  endtask

  task automatic test_reset();
    bus.in_vld = 1; bus.in_fst = 1; bus.in_data = 32'hDEAD; bus.rd_release = 0;
    reset = 0; model_reset();
    #3;
    checks++; if (bus.in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy got=%b exp=0", bus.in_rdy); end
    checks++; if (bus.mem_wr_vld !== 1'b0) begin failures++; $display("FAIL reset_wr_vld got=%b exp=0", bus.mem_wr_vld); end
    checks++; if (bus.rd_vld !== 1'b0 || bus.rd_bank !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b%b exp=00", bus.rd_vld, bus.rd_bank); end
    checks++; if (bus.drop_count !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", bus.drop_count); end
    @(posedge clk); #1;
    checks++; if (bus.mem_wr_vld !== 1'b0) begin failures++; $display("FAIL reset_held_wr got=%b exp=0", bus.mem_wr_vld); end
    do_reset();
    checks++; if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy_after got=%b exp=1", bus.in_rdy); end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < FL; i++) begin
      cyc(1, i == 0, 32'hA0 + i, 0);
      checks++; if (bus.mem_wr_vld !== 1'b1 || bus.mem_wr_address !== AW'(i) || bus.mem_wr_data !== 32'hA0 + i)
        begin failures++; $display("FAIL basic_write%0d got=%b/%0d/%h exp=1/%0d/%h", i, bus.mem_wr_vld, bus.mem_wr_address, bus.mem_wr_data, i, 32'hA0 + i); end
      checks++; if (bus.frame_done !== (i == FL - 1)) begin failures++; $display("FAIL basic_done%0d got=%b exp=%b", i, bus.frame_done, i == FL - 1); end
    end
    cyc(0, 0, '0, 0);
    checks++; if (bus.rd_vld !== 1'b1 || bus.rd_bank !== 1'b0) begin failures++; $display("FAIL basic_rd got=%b/%b exp=1/0", bus.rd_vld, bus.rd_bank); end
    checks++; if (bus.mem_wr_vld !== 1'b0 || bus.frame_done !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b/%b exp=0/0", bus.mem_wr_vld, bus.frame_done); end
  endtask

  task automatic test_garbage();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 32'h6000 + i, 0);
      checks++; if (bus.mem_wr_vld !== 1'b0) begin failures++; $display("FAIL garbage_nowrite%0d got=%b exp=0", i, bus.mem_wr_vld); end
    end
    checks++; if (bus.drop_count !== 8'd3) begin failures++; $display("FAIL garbage_drop got=%0d exp=3", bus.drop_count); end
    for (int i = 0; i < FL; i++) begin
      cyc(1, i == 0, 32'hB0 + i, 0);
      checks++; if (bus.mem_wr_vld !== 1'b1 || bus.mem_wr_address !== AW'(i)) begin failures++; $display("FAIL garbage_frame%0d got=%b/%0d exp=1/%0d", i, bus.mem_wr_vld, bus.mem_wr_address, i); end
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < FL; i++) begin
        cyc(1, i == 0, 32'h100 * f + i, 0);
        checks++; if (bus.mem_wr_address !== AW'(64 * f + i)) begin failures++; $display("FAIL bp_addr f%0d i%0d got=%0d exp=%0d", f, i, bus.mem_wr_address, 64 * f + i); end
      end
    checks++; if (bus.in_rdy !== 1'b0) begin failures++; $display("FAIL bp_rdy_low got=%b exp=0", bus.in_rdy); end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 32'hC0, 0);
      checks++; if (bus.mem_wr_vld !== 1'b0 || bus.in_rdy !== 1'b0 || bus.drop_count !== 8'd0)
        begin failures++; $display("FAIL bp_held%0d got=%b/%b/%0d exp=0/0/0", i, bus.mem_wr_vld, bus.in_rdy, bus.drop_count); end
    end
    cyc(1, 1, 32'hC0, 1);
    checks++; if (bus.rd_bank !== 1'b1 || bus.in_rdy !== 1'b1 || bus.mem_wr_vld !== 1'b0)
      begin failures++; $display("FAIL bp_release got=%b/%b/%b exp=1/1/0", bus.rd_bank, bus.in_rdy, bus.mem_wr_vld); end
    for (int i = 0; i < FL; i++) begin
      cyc(1, i == 0, 32'hC0 + i, 0);
      checks++; if (bus.mem_wr_vld !== 1'b1 || bus.mem_wr_address !== AW'(i) || bus.mem_wr_data !== 32'hC0 + i)
        begin failures++; $display("FAIL bp_frame3_%0d got=%b/%0d/%h exp=1/%0d/%h", i, bus.mem_wr_vld, bus.mem_wr_address, bus.mem_wr_data, i, 32'hC0 + i); end
    end
    checks++; if (bus.in_rdy !== 1'b0) begin failures++; $display("FAIL bp_full_again got=%b exp=0", bus.in_rdy); end
  endtask

  task automatic test_restart();
    int errs, dones;
    errs = 0; dones = 0;
    do_reset();
    cyc(1, 1, 32'hE0, 0); errs += bus.err_restart; dones += bus.frame_done;
    cyc(1, 0, 32'hE1, 0); errs += bus.err_restart; dones += bus.frame_done;
    cyc(1, 0, 32'hE2, 0); errs += bus.err_restart; dones += bus.frame_done;
    cyc(1, 1, 32'hB0, 0);
    checks++; if (bus.err_restart !== 1'b1 || bus.mem_wr_address !== AW'(0) || bus.mem_wr_data !== 32'hB0)
      begin failures++; $display("FAIL restart_first got=%b/%0d/%h exp=1/0/b0", bus.err_restart, bus.mem_wr_address, bus.mem_wr_data); end
    errs += bus.err_restart; dones += bus.frame_done;
    for (int i = 1; i < FL; i++) begin
      cyc(1, 0, 32'hB0 + i, 0);
      checks++; if (bus.mem_wr_address !== AW'(i)) begin failures++; $display("FAIL restart_addr%0d got=%0d exp=%0d", i, bus.mem_wr_address, i); end
      errs += bus.err_restart; dones += bus.frame_done;
    end
    checks++; if (bus.frame_done !== 1'b1) begin failures++; $display("FAIL restart_done_last got=%b exp=1", bus.frame_done); end
    cyc(0, 0, '0, 0); errs += bus.err_restart; dones += bus.frame_done;
    checks++; if (errs != 1 || dones != 1) begin failures++; $display("FAIL restart_pulses got=err%0d/done%0d exp=1/1", errs, dones); end
    checks++; if (bus.rd_vld !== 1'b1 || bus.in_rdy !== 1'b1) begin failures++; $display("FAIL restart_full1 got=%b/%b exp=1/1", bus.rd_vld, bus.in_rdy); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < FL; i++) cyc(1, i == 0, 32'h300 + i, 0);
    for (int i = 0; i < FL - 1; i++) cyc(1, i == 0, 32'h400 + i, 0);
    cyc(1, 0, 32'h400 + FL - 1, 1);
    checks++; if (bus.frame_done !== 1'b1 || bus.mem_wr_address !== AW'(64 + FL - 1) || bus.rd_bank !== 1'b1 || bus.in_rdy !== 1'b1)
      begin failures++; $display("FAIL simul_edge got=%b/%0d/%b/%b exp=1/%0d/1/1", bus.frame_done, bus.mem_wr_address, bus.rd_bank, bus.in_rdy, 64 + FL - 1); end
    cyc(0, 0, '0, 0);
    checks++; if (bus.rd_vld !== 1'b1) begin failures++; $display("FAIL simul_still1 got=%b exp=1", bus.rd_vld); end
    cyc(1, 1, 32'h500, 0);
    checks++; if (bus.mem_wr_address !== AW'(0)) begin failures++; $display("FAIL simul_wbank_wrap got=%0d exp=0", bus.mem_wr_address); end
    cyc(0, 0, '0, 1);
    checks++; if (bus.rd_bank !== 1'b0) begin failures++; $display("FAIL simul_rel_to0 got=%b exp=0", bus.rd_bank); end
    cyc(0, 0, '0, 1);
    checks++; if (bus.rd_bank !== 1'b0 || bus.rd_vld !== 1'b0) begin failures++; $display("FAIL simul_rel_empty got=%b/%b exp=0/0", bus.rd_bank, bus.rd_vld); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1, 1, 32'h700, 0);
    cyc(1, 0, 32'h701, 0);
    bus.in_vld = 0;
    #3 reset = 0; model_reset();
    #1;
    checks++; if (bus.mem_wr_vld !== 1'b0 || bus.in_rdy !== 1'b0 || bus.mem_wr_address !== AW'(0))
      begin failures++; $display("FAIL areset_now got=%b/%b/%0d exp=0/0/0", bus.mem_wr_vld, bus.in_rdy, bus.mem_wr_address); end
    @(posedge clk); #2 reset = 1;
    @(negedge clk);
    cyc(0, 0, '0, 0);
    checks++; if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL areset_rdy got=%b exp=1", bus.in_rdy); end
    cyc(1, 1, 32'h800, 0);
    checks++; if (bus.mem_wr_vld !== 1'b1 || bus.mem_wr_address !== AW'(0)) begin failures++; $display("FAIL areset_frame got=%b/%0d exp=1/0", bus.mem_wr_vld, bus.mem_wr_address); end
  endtask

  task automatic test_drop_sat();
    do_reset();
    for (int i = 0; i < 260; i++) cyc(1, 0, 32'(i), 0);
    checks++; if (bus.drop_count !== 8'd255) begin failures++; $display("FAIL drop_sat got=%0d exp=255", bus.drop_count); end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom, $urandom_range(0, 9) < 3);
      checks++;
      if (bus.mem_wr_vld !== e_wr_vld || bus.frame_done !== e_done || bus.err_restart !== e_err ||
          bus.rd_vld !== e_rdvld || bus.in_rdy !== e_rdy || bus.rd_bank !== m_rbank[0] ||
          bus.drop_count !== 8'(m_drop) ||
          (e_wr_vld && (bus.mem_wr_address !== e_addr || bus.mem_wr_data !== e_data))) begin
        failures++; bad++;
        if (bad < 10)
          $display("FAIL random_cyc%0d got wv%b a%0d d%h fd%b er%b rv%b rb%b ry%b dc%0d exp wv%b a%0d d%h fd%b er%b rv%b rb%0d ry%b dc%0d",
                   n, bus.mem_wr_vld, bus.mem_wr_address, bus.mem_wr_data, bus.frame_done, bus.err_restart,
                   bus.rd_vld, bus.rd_bank, bus.in_rdy, bus.drop_count,
                   e_wr_vld, e_addr, e_data, e_done, e_err, e_rdvld, m_rbank, e_rdy, m_drop);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 0;
    bus.in_vld = 0; bus.in_fst = 0; bus.in_data = '0; bus.rd_release = 0;
    model_reset();
    #2;
    test_reset();
    test_basic();
    test_garbage();
    test_back_pressure();
    test_restart();
    test_simultaneous();
    test_async_reset();
    test_drop_sat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
